traffic_seq_ctrl: RTL and testbench

Sequencing controller for the traffic-light datapath: the regfile with four 3-bit entries, the input/ALU mux, the ALU and the >2/>6 comparators. It initialises the datapath registers and steps a phase counter once per `tick`. It reads the comparator flags to end each light phase and drives the north-south and east-west lamp outputs. The counter lives in the datapath; this block contains only the FSM, lamp registers and control decode.

---
 rtl/traffic_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_traffic_seq_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_seq_ctrl.sv
// Traffic-light sequencing controller: FSM, lamp registers and Mealy control decode
// for the external regfile / ALU / comparator datapath that holds the phase counter.
//
// state     | meaning
// INIT_ONE  | write constant 1 into ONE_REG
// INIT_CNT  | clear the phase counter in CNT_REG
// NS_GREEN  | north-south green, 7 ticks
// NS_YELLOW | north-south yellow, 3 ticks
// EW_GREEN  | east-west green, 7 ticks
// EW_YELLOW | east-west yellow, 3 ticks
// FLASH     | maintenance flashing yellow on both roads
module traffic_seq_ctrl #(
  parameter logic [1:0] ALU_ADD = 2'b00,
  parameter logic [1:0] CNT_REG = 2'd0,
  parameter logic [1:0] ONE_REG = 2'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       flash,
  input  logic       gt_2signal,
  input  logic       gt_6signal,
  output logic       sel_input,
  output logic [2:0] in_dtpath,
  output logic       REA,
  output logic       REB,
  output logic [1:0] RAA,
  output logic [1:0] RAB,
  output logic [1:0] WA,
  output logic       WEn,
  output logic [1:0] alu_sel,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [2:0] phase
);

  localparam logic [2:0] S_INIT_ONE  = 3'd0;
  localparam logic [2:0] S_INIT_CNT  = 3'd1;
  localparam logic [2:0] S_NS_GREEN  = 3'd2;
  localparam logic [2:0] S_NS_YELLOW = 3'd3;
  localparam logic [2:0] S_EW_GREEN  = 3'd4;
  localparam logic [2:0] S_EW_YELLOW = 3'd5;
  localparam logic [2:0] S_FLASH     = 3'd6;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       blink;
  logic       blink_nxt;
  logic       thresh;

  function automatic logic [5:0] lamps_for(input logic [2:0] st, input logic bl);
    case (st)
      S_NS_GREEN:  lamps_for = {LAMP_G, LAMP_R};
      S_NS_YELLOW: lamps_for = {LAMP_Y, LAMP_R};
      S_EW_GREEN:  lamps_for = {LAMP_R, LAMP_G};
      S_EW_YELLOW: lamps_for = {LAMP_R, LAMP_Y};
      S_FLASH:     lamps_for = {1'b0, bl, 1'b0, 1'b0, bl, 1'b0};
      default:     lamps_for = {LAMP_R, LAMP_R};
    endcase
  endfunction

  function automatic logic [2:0] advance(input logic [2:0] st);
    case (st)
      S_NS_GREEN:  advance = S_NS_YELLOW;
      S_NS_YELLOW: advance = S_EW_GREEN;
      S_EW_GREEN:  advance = S_EW_YELLOW;
      default:     advance = S_NS_GREEN;
    endcase
  endfunction

  assign thresh = ((state == S_NS_GREEN) || (state == S_EW_GREEN)) ? gt_6signal : gt_2signal;
  assign phase  = state;

  always_comb begin
    sel_input = 1'b0;
    in_dtpath = 3'd0;
    REA       = 1'b0;
    REB       = 1'b0;
    RAA       = 2'd0;
    RAB       = 2'd0;
    WA        = 2'd0;
    WEn       = 1'b0;
    alu_sel   = 2'd0;
    state_nxt = state;
    blink_nxt = blink;
    case (state)
      S_INIT_ONE: begin
        in_dtpath = 3'd1;
        WA        = ONE_REG;
        WEn       = 1'b1;
        state_nxt = S_INIT_CNT;
      end
      S_INIT_CNT: begin
        WA        = CNT_REG;
        WEn       = 1'b1;
        state_nxt = S_NS_GREEN;
      end
      S_NS_GREEN, S_NS_YELLOW, S_EW_GREEN, S_EW_YELLOW: begin
        if (tick) begin
          REA     = 1'b1;
          REB     = 1'b1;
          RAA     = CNT_REG;
          RAB     = ONE_REG;
          alu_sel = ALU_ADD;
          WA      = CNT_REG;
          WEn     = 1'b1;
          // flash outranks the threshold; both paths clear the counter
          if (flash) begin
            state_nxt = S_FLASH;
            blink_nxt = 1'b0;
          end else if (thresh) begin
            state_nxt = advance(state);
          end else begin
            sel_input = 1'b1;
          end
        end
      end
      S_FLASH: begin
        if (tick) begin
          if (flash) begin
            blink_nxt = ~blink;
          end else begin
            state_nxt = S_NS_GREEN;
            blink_nxt = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = S_INIT_ONE;
        blink_nxt = 1'b0;
      end
    endcase
    // keep the regfile untouched while reset is held
    if (!rst_n) begin
      sel_input = 1'b0;
      in_dtpath = 3'd0;
      REA       = 1'b0;
      REB       = 1'b0;
      RAA       = 2'd0;
      RAB       = 2'd0;
      WA        = 2'd0;
      WEn       = 1'b0;
      alu_sel   = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT_ONE;
      blink    <= 1'b0;
      ns_light <= LAMP_R;
      ew_light <= LAMP_R;
    end else begin
      state                <= state_nxt;
      blink                <= blink_nxt;
      {ns_light, ew_light} <= lamps_for(state_nxt, blink_nxt);
    end
  end

endmodule

// File: tb/tb_traffic_seq_ctrl.sv
// Bench for traffic_seq_ctrl: behavioural regfile/ALU/comparator datapath plus a
// tick-counting reference model of the light sequence.
module tb_traffic_seq_ctrl;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] CNT_REG = 2'd0;
  localparam logic [1:0] ONE_REG = 2'd1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       flash = 1'b0;
  logic       gt_2signal;
  logic       gt_6signal;
  logic       sel_input;
  logic [2:0] in_dtpath;
  logic       REA, REB;
  logic [1:0] RAA, RAB, WA;
  logic       WEn;
  logic [1:0] alu_sel;
  logic [2:0] ns_light, ew_light, phase;

  int checks = 0;
  int failures = 0;

  traffic_seq_ctrl #(.ALU_ADD(ALU_ADD), .CNT_REG(CNT_REG), .ONE_REG(ONE_REG)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .flash(flash),
    .gt_2signal(gt_2signal), .gt_6signal(gt_6signal),
    .sel_input(sel_input), .in_dtpath(in_dtpath),
    .REA(REA), .REB(REB), .RAA(RAA), .RAB(RAB), .WA(WA), .WEn(WEn),
    .alu_sel(alu_sel), .ns_light(ns_light), .ew_light(ew_light), .phase(phase)
  );

  always #5 clk = ~clk;

  // datapath: garbage power-up contents prove the init writes happen
  logic [2:0] rf [4] = '{3'd5, 3'd6, 3'd7, 3'd3};
  logic [2:0] rd_a, rd_b, alu_y, wdata;
  assign rd_a       = REA ? rf[RAA] : 3'd0;
  assign rd_b       = REB ? rf[RAB] : 3'd0;
  assign alu_y      = (alu_sel == ALU_ADD) ? 3'(rd_a + rd_b) : 3'd0;
  assign wdata      = sel_input ? alu_y : in_dtpath;
  assign gt_2signal = alu_y > 3'd2;
  assign gt_6signal = alu_y > 3'd6;
  always @(posedge clk) if (WEn) rf[WA] <= wdata;

  // reference model: phase code, ticks spent in phase, blink bit
  int ref_ph, ref_cnt;
  bit ref_blink;

  function automatic int plen(input int ph);
    return (ph == 2 || ph == 4) ? 7 : 3;
  endfunction

  function automatic logic [5:0] ref_lamps(input int ph, input bit b);
    case (ph)
      2: return 6'b001_100;
      3: return 6'b010_100;
      4: return 6'b100_001;
      5: return 6'b100_010;
      6: return {1'b0, b, 1'b0, 1'b0, b, 1'b0};
      default: return 6'b100_100;
    endcase
  endfunction

  task automatic ref_reset();
    ref_ph = 0; ref_cnt = 0; ref_blink = 0;
  endtask

  task automatic ref_update(input bit t, input bit f);
    if (ref_ph == 0) ref_ph = 1;
    else if (ref_ph == 1) begin ref_ph = 2; ref_cnt = 0; end
    else if (ref_ph == 6) begin
      if (t) begin
        if (f) ref_blink = !ref_blink;
        else begin ref_ph = 2; ref_blink = 0; ref_cnt = 0; end
      end
    end else if (t) begin
      if (f) begin ref_ph = 6; ref_cnt = 0; ref_blink = 0; end
      else if (ref_cnt + 1 >= plen(ref_ph)) begin
        ref_ph = (ref_ph == 5) ? 2 : ref_ph + 1;
        ref_cnt = 0;
      end else ref_cnt++;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called just after a rising edge; returns just after the next rising edge
  task automatic step(input bit t, input bit f);
    bit wr, rd, sel;
    logic [1:0] wa;
    logic [2:0] din;
    tick = t; flash = f;
    @(negedge clk);
    wr = 0; rd = 0; sel = 0; wa = 2'd0; din = 3'd0;
    if (ref_ph == 0) begin wr = 1; wa = ONE_REG; din = 3'd1; end
    else if (ref_ph == 1) begin wr = 1; wa = CNT_REG; end
    else if (ref_ph != 6 && t) begin
      wr = 1; rd = 1; wa = CNT_REG;
      sel = !f && (ref_cnt + 1 < plen(ref_ph));
    end
    chk("WEn", {7'd0, WEn}, {7'd0, wr});
    chk("REA", {7'd0, REA}, {7'd0, rd});
    chk("sel_input", {7'd0, sel_input}, {7'd0, sel});
    if (wr) chk("WA", {6'd0, WA}, {6'd0, wa});
    if (wr && !sel) chk("in_dtpath", {5'd0, in_dtpath}, {5'd0, din});
    if (rd) chk("rd_addr", {REB, alu_sel, RAA, RAB}, {1'b1, ALU_ADD, CNT_REG, ONE_REG});
    if (ref_ph != 6) chk("safety", {7'd0, (ns_light == 3'b100) || (ew_light == 3'b100)}, 8'd1);
    ref_update(t, f);
    @(posedge clk); #1;
    chk("phase", {5'd0, phase}, 8'(ref_ph));
    chk("lamps", {2'd0, ns_light, ew_light}, {2'd0, ref_lamps(ref_ph, ref_blink)});
    if (ref_ph != 0) chk("one_reg", {5'd0, rf[ONE_REG]}, 8'd1);
    if (ref_ph >= 2) chk("counter", {5'd0, rf[CNT_REG]}, 8'(ref_cnt));
  endtask

  logic [2:0] flash_seq [4] = '{3'b010, 3'b000, 3'b010, 3'b000};
  bit fl;

  initial begin
    // reset held: inputs toggled, nothing moves
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      tick = 1'($urandom); flash = 1'($urandom);
      @(negedge clk);
      chk("rst_lamps", {2'd0, ns_light, ew_light}, 8'b00_100_100);
      chk("rst_phase", {5'd0, phase}, 8'd0);
      chk("rst_WEn", {7'd0, WEn}, 8'd0);
    end

    // release with tick held high through init
    @(posedge clk); #1;
    rst_n = 1'b1;
    ref_reset();
    step(1, 0);
    step(1, 0);
    chk("init_phase", {5'd0, phase}, 8'd2);

    // full cycle: 20 ticks, 5 cycles apart
    for (int i = 0; i < 20; i++) begin
      step(1, 0);
      for (int j = 0; j < 4; j++) step(0, 0);
    end
    chk("cycle_back_ns_green", {5'd0, phase}, 8'd2);

    // flash entry on the 4th NS_GREEN tick
    for (int i = 0; i < 3; i++) begin step(1, 0); step(0, 0); end
    step(1, 1);
    chk("flash_entry", {5'd0, phase}, 8'd6);
    for (int i = 0; i < 4; i++) begin
      step(0, 1'($urandom));
      step(1, 1);
      chk("flash_ns", {5'd0, ns_light}, {5'd0, flash_seq[i]});
      chk("flash_ew", {5'd0, ew_light}, {5'd0, flash_seq[i]});
    end

    // flash exit, then exactly 7 ticks to NS_YELLOW
    step(1, 0);
    chk("flash_exit", {2'd0, phase, ns_light}, {2'd0, 3'd2, 3'b001});
    for (int i = 0; i < 6; i++) step(1, 0);
    chk("ns_green_6", {5'd0, phase}, 8'd2);
    step(1, 0);
    chk("ns_yellow_7", {5'd0, phase}, 8'd3);

    // randomized ticks, back-to-back ticks and flash requests
    fl = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) fl = !fl;
      step(($urandom_range(0, 2) == 0), fl);
    end
    for (int i = 0; i < 3; i++) step(1, 0);

    // reset mid-phase on the first EW_YELLOW tick
    for (int k = 0; k < 40 && ref_ph != 5; k++) step(1, 0);
    chk("reach_ew_yellow", {5'd0, phase}, 8'd5);
    tick = 1'b1; flash = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_lamps", {2'd0, ns_light, ew_light}, 8'b00_100_100);
    chk("midrst_phase", {5'd0, phase}, 8'd0);
    chk("midrst_WEn", {7'd0, WEn}, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ref_reset();
    step(0, 0);
    step(0, 0);
    for (int i = 0; i < 7; i++) step(1, 0);
    chk("post_rst_ns_yellow", {5'd0, phase}, 8'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
